// File: rtl/jamma_pkg.sv
// jamma_pkg: shared constants and slot-to-bit map for the serial joystick reader
package jamma_pkg;
  localparam int FRAME_SLOTS = 26;
  localparam int JOY_START = 8;
  localparam int JOY_COIN = 9;
  localparam int JOY_RST = 11;
  localparam logic [11:0] JOY_IDLE = 12'hFFF;
  localparam logic [3:0] DIR_MAP [8] = '{4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  localparam logic [3:0] BTN_MAP [4] = '{4'd10, 4'd11, 4'd9, 4'd7};
  typedef struct packed {
    logic p1;
    logic p2;
    logic [3:0] idx;
  } slot_map_t;
  // Slots 0 and 1 carry no player bits; the rest map into one of the two shadow words.
  function automatic slot_map_t map_slot(input logic [4:0] slot);
    slot_map_t m;
    m = '0;
    if (slot >= 5'd2 && slot <= 5'd9) begin
      m.p1 = 1'b1;
      m.idx = DIR_MAP[3'(slot - 5'd2)];
    end else if (slot >= 5'd10 && slot <= 5'd17) begin
      m.p2 = 1'b1;
      m.idx = DIR_MAP[3'(slot - 5'd10)];
    end else if (slot >= 5'd18 && slot <= 5'd21) begin
      m.p2 = 1'b1;
      m.idx = BTN_MAP[2'(slot - 5'd18)];
    end else if (slot >= 5'd22 && slot <= 5'd25) begin
      m.p1 = 1'b1;
      m.idx = BTN_MAP[2'(slot - 5'd22)];
    end
    return m;
  endfunction
endpackage

// File: rtl/joy_frame_filter.sv
// joy_frame_filter: releases a frame pair only after it repeats for STABLE_FRAMES frames
module joy_frame_filter
  import jamma_pkg::*;
#(
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [11:0] frame1,
  input  logic [11:0] frame2,
  output logic [11:0] joy1,
  output logic [11:0] joy2,
  output logic        stb
);
  logic [23:0] prev;
  logic [2:0] agree, agree_n;
  logic load;
  // Agreement count for the incoming frame and the decision to publish it.
  always_comb begin
    agree_n = ({frame1, frame2} == prev) ? ((agree == 3'd7) ? agree : agree + 3'd1) : 3'd1;
    load = valid && agree_n == 3'(STABLE_FRAMES) && {frame1, frame2} != {joy1, joy2};
  end
  // Both words load together so the core never sees a half-updated pair.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= {JOY_IDLE, JOY_IDLE};
      agree <= '0;
      joy1 <= JOY_IDLE;
      joy2 <= JOY_IDLE;
      stb <= 1'b0;
    end else begin
      stb <= load;
      if (valid) begin
        prev <= {frame1, frame2};
        agree <= agree_n;
      end
      if (load) begin
        joy1 <= frame1;
        joy2 <= frame2;
      end
    end
endmodule

// File: rtl/jamma_joy_reader.sv
// jamma_joy_reader: drives the external shift chain and deserialises two player words
module jamma_joy_reader
  import jamma_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int STABLE_FRAMES = 2
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  input  logic        JOY_DATA,
  output logic [11:0] O_JOY1,
  output logic [11:0] O_JOY2,
  output logic        O_FRAME_STB
);
  logic [7:0] div;
  logic [4:0] slot, slot_n;
  logic [1:0] sync;
  logic [11:0] sh1, sh2, sh1_n, sh2_n;
  logic wrap, rise, frame_end;
  slot_map_t m;
  // Tick decode and the shadow words with the bit of the slot being left written in.
  always_comb begin
    wrap = div == 8'(CLK_DIV - 1);
    rise = wrap && !JOY_CLK;
    frame_end = rise && slot == 5'(FRAME_SLOTS - 1);
    slot_n = frame_end ? '0 : slot + 5'd1;
    m = map_slot(slot);
    sh1_n = sh1;
    sh2_n = sh2;
    if (m.p1) sh1_n[m.idx] = sync[1];
    if (m.p2) sh2_n[m.idx] = sync[1];
  end
  // Divider, shift clock, slot counter, load strobe, synchroniser and shadow capture.
  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) begin
      div <= '0;
      JOY_CLK <= 1'b0;
      JOY_LOAD <= 1'b0;
      slot <= '0;
      sync <= 2'b11;
      sh1 <= JOY_IDLE;
      sh2 <= JOY_IDLE;
    end else begin
      div <= wrap ? '0 : div + 8'd1;
      sync <= {sync[0], JOY_DATA};
      if (wrap) JOY_CLK <= !JOY_CLK;
      if (rise) begin
        slot <= slot_n;
        JOY_LOAD <= slot_n != '0;
        sh1 <= sh1_n;
        sh2 <= sh2_n;
      end
    end
  joy_frame_filter #(.STABLE_FRAMES(STABLE_FRAMES)) u_filter (
    .clk(I_CLK),
    .rst(I_RESET),
    .valid(frame_end),
    .frame1(sh1_n),
    .frame2(sh2_n),
    .joy1(O_JOY1),
    .joy2(O_JOY2),
    .stb(O_FRAME_STB)
  );
endmodule

// File: tb/tb_jamma_joy_reader.sv
// tb_jamma_joy_reader: directed checks of two reader instances against a serial chain model
module tb_jamma_joy_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic jclk_a, load_a, stb_a, jclk_b, load_b, stb_b;
  logic data_a = 1'b1;
  logic data_b = 1'b1;
  logic [11:0] j1_a, j2_a, j1_b, j2_b;
  logic [25:0] pat_a = '1;
  logic [25:0] pat_b = '1;
  logic pj_a = 1'b0;
  logic pj_b = 1'b0;
  int checks = 0;
  int failures = 0;
  int slot_a = 0;
  int slot_b = 0;
  int cyc = 0;
  int stbs_a = 0;
  int lows, t1, t2, s0, bud;
  logic [23:0] walk [26] = '{
    24'hFFFFFF, 24'hFFFFFF, 24'hEFFFFF, 24'hFBFFFF, 24'hFDFFFF, 24'hFEFFFF, 24'hFF7FFF,
    24'hFFBFFF, 24'hFFDFFF, 24'hFFEFFF, 24'hFFFEFF, 24'hFFFFBF, 24'hFFFFDF, 24'hFFFFEF,
    24'hFFFFF7, 24'hFFFFFB, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFBFF, 24'hFFF7FF, 24'hFFFDFF,
    24'hFFFF7F, 24'hBFFFFF, 24'h7FFFFF, 24'hDFFFFF, 24'hF7FFFF};

  always #5 clk = ~clk;

  jamma_joy_reader #(.CLK_DIV(2), .STABLE_FRAMES(2)) dut_a (
    .I_CLK(clk), .I_RESET(rst), .JOY_CLK(jclk_a), .JOY_LOAD(load_a), .JOY_DATA(data_a),
    .O_JOY1(j1_a), .O_JOY2(j2_a), .O_FRAME_STB(stb_a));

  jamma_joy_reader #(.CLK_DIV(255), .STABLE_FRAMES(1)) dut_b (
    .I_CLK(clk), .I_RESET(rst), .JOY_CLK(jclk_b), .JOY_LOAD(load_b), .JOY_DATA(data_b),
    .O_JOY1(j1_b), .O_JOY2(j2_b), .O_FRAME_STB(stb_b));

  // External chain model: reloads on JOY_LOAD low, advances one slot per JOY_CLK rise.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      slot_a = 0;
      slot_b = 0;
    end else begin
      if (jclk_a && !pj_a) slot_a = load_a ? slot_a + 1 : 0;
      if (jclk_b && !pj_b) slot_b = load_b ? slot_b + 1 : 0;
    end
    pj_a = jclk_a;
    pj_b = jclk_b;
    data_a = pat_a[slot_a];
    data_b = pat_b[slot_b];
    stbs_a += int'(stb_a);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input bit sel_b, input int n, output int lo);
    int seen, budget;
    logic pl, l;
    seen = 0;
    lo = 0;
    budget = n * 52 * (sel_b ? 255 : 2) + 600;
    pl = sel_b ? load_b : load_a;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      l = sel_b ? load_b : load_a;
      if (!l) lo++;
      if (pl && !l) seen++;
      pl = l;
    end
    #1;
    chk("frame_wait", seen, n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_jclk", jclk_a, 0);
    chk("rst_load", load_a, 0);
    chk("rst_j1", j1_a, 12'hFFF);
    chk("rst_j2", j2_a, 12'hFFF);
    chk("rst_stb", stb_a, 0);
    rst = 1'b0;
    wait_frames(0, 1, lows);
    t1 = cyc;
    wait_frames(0, 1, lows);
    chk("load_low_clks", lows, 4);
    chk("frame_len", cyc - t1, 104);
    chk("idle_j1", j1_a, 12'hFFF);
    chk("idle_j2", j2_a, 12'hFFF);
    chk("idle_nostb", stbs_a, 0);
    pat_a = ~((26'd1 << 9) | (26'd1 << 20));
    wait_frames(0, 1, lows);
    chk("fire1_j1", j1_a, 12'hFFF);
    chk("fire1_j2", j2_a, 12'hFFF);
    chk("fire1_nostb", stbs_a, 0);
    wait_frames(0, 1, lows);
    chk("fire2_stb_now", stb_a, 1);
    chk("fire2_j1", j1_a, 12'hFFE);
    chk("fire2_j2", j2_a, 12'hDFF);
    @(negedge clk);
    #1;
    chk("fire2_stb_one", stb_a, 0);
    chk("fire2_stb_cnt", stbs_a, 1);
    pat_a = '1;
    wait_frames(0, 2, lows);
    chk("back_idle", {j1_a, j2_a}, 24'hFFFFFF);
    s0 = stbs_a;
    pat_a = ~(26'd1 << 3);
    wait_frames(0, 1, lows);
    pat_a = '1;
    chk("glitch_j1", j1_a, 12'hFFF);
    wait_frames(0, 2, lows);
    chk("glitch_after", {j1_a, j2_a}, 24'hFFFFFF);
    chk("glitch_nostb", stbs_a - s0, 0);
    for (int i = 0; i < 26; i++) begin
      pat_a = ~(26'd1 << i);
      wait_frames(0, 2, lows);
      chk($sformatf("walk_slot%0d", i), {j1_a, j2_a}, walk[i]);
    end
    pat_a = ~((26'd1 << 9) | (26'd1 << 20));
    bud = 200;
    while (slot_a != 14 && bud > 0) begin
      @(negedge clk);
      #1;
      bud--;
    end
    chk("reach_slot14", slot_a, 14);
    chk("pre_rst_j1", j1_a, 12'hF7F);
    rst = 1'b1;
    #1;
    chk("async_rst_j1", j1_a, 12'hFFF);
    chk("async_rst_j2", j2_a, 12'hFFF);
    chk("async_rst_load", load_a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_frames(0, 1, lows);
    chk("post_rst1", {j1_a, j2_a}, 24'hFFFFFF);
    wait_frames(0, 1, lows);
    chk("post_rst2", {j1_a, j2_a}, 24'hFFEDFF);
    wait_frames(1, 1, lows);
    pat_b = ~((26'd1 << 9) | (26'd1 << 20));
    wait_frames(1, 1, lows);
    t1 = cyc;
    chk("b_stb1", stb_b, 1);
    chk("b_upd1", {j1_b, j2_b}, 24'hFFEDFF);
    pat_b = ~(26'd1 << 2);
    wait_frames(1, 1, lows);
    t2 = cyc;
    chk("b_stb2", stb_b, 1);
    chk("b_upd2", {j1_b, j2_b}, 24'hEFFFFF);
    chk("b_spacing", t2 - t1, 13260);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
